// File: rtl/commu_rx_parse_if.sv
// Byte-stream and status bundle between the commu link receiver and the packet parser.
// The parser sits on the slave side; the byte source and status consumer use master.
interface commu_rx_parse_if;
   logic [7:0]  rx_data;
   logic        rx_vld;
   logic [7:0]  pay_data;
   logic        pay_vld;
   logic        pkt_done;
   logic        pkt_ok;
   logic        pkt_err_crc;
   logic        pkt_err_tout;
   logic [7:0]  pkt_type;
   logic [15:0] pkt_seq;
   logic [15:0] cnt_ok;
   logic [15:0] cnt_err;

   modport slave (
      input  rx_data, rx_vld,
      output pay_data, pay_vld, pkt_done, pkt_ok, pkt_err_crc, pkt_err_tout,
             pkt_type, pkt_seq, cnt_ok, cnt_err
   );

   modport master (
      output rx_data, rx_vld,
      input  pay_data, pay_vld, pkt_done, pkt_ok, pkt_err_crc, pkt_err_tout,
             pkt_type, pkt_seq, cnt_ok, cnt_err
   );
endinterface

// File: rtl/commu_rx_parse.sv
// Receive-side commu packet parser: sync hunt, header decode, payload forwarding,
// XOR check byte, inter-byte gap timeout and saturating good/bad packet counters.
module commu_rx_parse #(
   parameter int          SIM_LEN = 0,
   parameter logic [15:0] TOUT    = 16'd1000
) (
   input  logic             clk_sys,
   input  logic             rst,
   input  logic [7:0]       cfg_sample,
   commu_rx_parse_if.slave  bus
);
   typedef enum logic [2:0] {S_IDLE, S_SYNC1, S_HEAD, S_LOAD, S_CHK} state_t;

   state_t      state_q, state_d;
   logic [15:0] len_load_q, len_load_d, len_cur_q, len_cur_d;
   logic [15:0] cnt_q, cnt_d, gap_q, gap_d;
   logic [7:0]  xor_q, xor_d;
   logic [7:0]  sh_type_q, sh_type_d;
   logic [15:0] sh_seq_q, sh_seq_d;
   logic [7:0]  pay_data_q, pay_data_d;
   logic        pay_vld_q, pay_vld_d;
   logic        done_q, done_d, ok_q, ok_d, crc_q, crc_d, tout_q, tout_d;
   logic [7:0]  type_q, type_d;
   logic [15:0] seq_q, seq_d, cnt_ok_q, cnt_ok_d, cnt_err_q, cnt_err_d;
   logic [15:0] len_lu, gap_inc;
   logic        in_pkt;

   // Payload length table shared with the transmit builder; unknown codes act as 20.
   always_comb begin
      case (cfg_sample)
         8'd10:   len_lu = (SIM_LEN != 0) ? 16'd90 : 16'd9000;
         8'd5:    len_lu = (SIM_LEN != 0) ? 16'd45 : 16'd4500;
         8'd2:    len_lu = (SIM_LEN != 0) ? 16'd18 : 16'd1800;
         8'd1:    len_lu = (SIM_LEN != 0) ? 16'd9  : 16'd900;
         default: len_lu = (SIM_LEN != 0) ? 16'd180 : 16'd18000;
      endcase
   end

   assign in_pkt  = (state_q == S_HEAD) || (state_q == S_LOAD) || (state_q == S_CHK);
   assign gap_inc = gap_q + 16'd1;

   always_comb begin
      state_d    = state_q;
      len_load_d = len_lu;
      len_cur_d  = len_cur_q;
      cnt_d      = cnt_q;
      gap_d      = gap_q;
      xor_d      = xor_q;
      sh_type_d  = sh_type_q;
      sh_seq_d   = sh_seq_q;
      pay_data_d = pay_data_q;
      pay_vld_d  = 1'b0;
      done_d     = 1'b0;
      ok_d       = 1'b0;
      crc_d      = 1'b0;
      tout_d     = 1'b0;
      type_d     = type_q;
      seq_d      = seq_q;
      cnt_ok_d   = cnt_ok_q;
      cnt_err_d  = cnt_err_q;

      // A byte arriving on the expiry cycle wins over the timeout.
      if (in_pkt && !bus.rx_vld) begin
         if (gap_inc == TOUT) begin
            done_d    = 1'b1;
            tout_d    = 1'b1;
            cnt_err_d = (cnt_err_q == 16'hFFFF) ? cnt_err_q : cnt_err_q + 16'd1;
            gap_d     = 16'd0;
            state_d   = S_IDLE;
         end else begin
            gap_d = gap_inc;
         end
      end

      if (bus.rx_vld) begin
         gap_d = 16'd0;
         case (state_q)
            S_IDLE: begin
               if (bus.rx_data == 8'hEB) begin
                  state_d   = S_SYNC1;
                  xor_d     = 8'hEB;
                  len_cur_d = len_load_q;
               end
            end
            S_SYNC1: begin
               if (bus.rx_data == 8'h90) begin
                  state_d = S_HEAD;
                  cnt_d   = 16'd2;
                  xor_d   = xor_q ^ bus.rx_data;
               end else if (bus.rx_data == 8'hEB) begin
                  xor_d     = 8'hEB;
                  len_cur_d = len_load_q;
               end else begin
                  state_d = S_IDLE;
               end
            end
            S_HEAD: begin
               xor_d = xor_q ^ bus.rx_data;
               if (cnt_q == 16'd2) sh_type_d = bus.rx_data;
               if (cnt_q == 16'd3) sh_seq_d[15:8] = bus.rx_data;
               if (cnt_q == 16'd4) sh_seq_d[7:0] = bus.rx_data;
               if (cnt_q == 16'd11) begin
                  state_d = S_LOAD;
                  cnt_d   = 16'd0;
               end else begin
                  cnt_d = cnt_q + 16'd1;
               end
            end
            S_LOAD: begin
               xor_d      = xor_q ^ bus.rx_data;
               pay_data_d = bus.rx_data;
               pay_vld_d  = 1'b1;
               cnt_d      = cnt_q + 16'd1;
               if (cnt_q == len_cur_q - 16'd1) state_d = S_CHK;
            end
            S_CHK: begin
               done_d  = 1'b1;
               state_d = S_IDLE;
               if (bus.rx_data == xor_q) begin
                  ok_d     = 1'b1;
                  type_d   = sh_type_q;
                  seq_d    = sh_seq_q;
                  cnt_ok_d = (cnt_ok_q == 16'hFFFF) ? cnt_ok_q : cnt_ok_q + 16'd1;
               end else begin
                  crc_d     = 1'b1;
                  cnt_err_d = (cnt_err_q == 16'hFFFF) ? cnt_err_q : cnt_err_q + 16'd1;
               end
            end
            default: state_d = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk_sys or posedge rst) begin
      if (rst) begin
         state_q    <= S_IDLE;
         len_load_q <= 16'd0;
         len_cur_q  <= 16'd0;
         cnt_q      <= 16'd0;
         gap_q      <= 16'd0;
         xor_q      <= 8'd0;
         sh_type_q  <= 8'd0;
         sh_seq_q   <= 16'd0;
         pay_data_q <= 8'd0;
         pay_vld_q  <= 1'b0;
         done_q     <= 1'b0;
         ok_q       <= 1'b0;
         crc_q      <= 1'b0;
         tout_q     <= 1'b0;
         type_q     <= 8'd0;
         seq_q      <= 16'd0;
         cnt_ok_q   <= 16'd0;
         cnt_err_q  <= 16'd0;
      end else begin
         state_q    <= state_d;
         len_load_q <= len_load_d;
         len_cur_q  <= len_cur_d;
         cnt_q      <= cnt_d;
         gap_q      <= gap_d;
         xor_q      <= xor_d;
         sh_type_q  <= sh_type_d;
         sh_seq_q   <= sh_seq_d;
         pay_data_q <= pay_data_d;
         pay_vld_q  <= pay_vld_d;
         done_q     <= done_d;
         ok_q       <= ok_d;
         crc_q      <= crc_d;
         tout_q     <= tout_d;
         type_q     <= type_d;
         seq_q      <= seq_d;
         cnt_ok_q   <= cnt_ok_d;
         cnt_err_q  <= cnt_err_d;
      end
   end

   assign bus.pay_data     = pay_data_q;
   assign bus.pay_vld      = pay_vld_q;
   assign bus.pkt_done     = done_q;
   assign bus.pkt_ok       = ok_q;
   assign bus.pkt_err_crc  = crc_q;
   assign bus.pkt_err_tout = tout_q;
   assign bus.pkt_type     = type_q;
   assign bus.pkt_seq      = seq_q;
   assign bus.cnt_ok       = cnt_ok_q;
   assign bus.cnt_err      = cnt_err_q;
endmodule

// File: doc/commu_rx_parse.md
Name: commu_rx_parse

Overview:
- Receive-side packet parser for the commu link; counterpart of the transmit packet builder.
- Takes the inbound byte stream and hunts for the 2-byte sync word, then walks header, payload and check byte.
- Payload length is derived from cfg_sample with the same table the transmitter uses.
- Forwards payload bytes downstream and reports per-packet status, sequence number and good/bad packet counters.

Parameters:
SIM_LEN, 0, 1 selects the short simulation payload table (180/90/45/18/9); 0 selects the full table (18000/9000/4500/1800/900)
TOUT, 16'd1000, max idle clk_sys cycles between accepted bytes inside a packet before abort

Ports:
clk_sys  in  1  system clock, all logic on rising edge
rst  in  1  asynchronous active-high reset
cfg_sample  in  8  sample-rate code: 20/10/5/2/1; any other value maps as 20
rx_data  in  8  inbound byte
rx_vld  in  1  rx_data valid this cycle; no backpressure
pay_data  out  8  payload byte
pay_vld  out  1  pay_data valid, 1 cycle per payload byte
pkt_done  out  1  1-cycle pulse at packet end or abort
pkt_ok  out  1  valid with pkt_done: packet good
pkt_err_crc  out  1  valid with pkt_done: check byte mismatch
pkt_err_tout  out  1  valid with pkt_done: gap timeout
pkt_type  out  8  header byte 2 of last completed good packet
pkt_seq  out  16  header bytes 3..4 (MSB first) of last good packet
cnt_ok  out  16  good packet count, saturates at 16'hFFFF
cnt_err  out  16  bad packet count (crc or timeout), saturates

Behaviour:
- Reset: every output 0; state IDLE; all counters and accumulators 0.
- Packet format: 12 header bytes, then len_load payload bytes, then 1 check byte.
- Header bytes: 0 = 0xEB, 1 = 0x90, 2 = type, 3..4 = seq, 5..11 = reserved (ignored).
- len_load: registered lookup of cfg_sample every cycle. Captured into len_cur when byte 0xEB is accepted in IDLE. A cfg_sample change mid-packet has no effect on the current packet.
- Check byte: 8-bit XOR of all header and payload bytes, bytes 0 through last payload.
- States:
  - IDLE: on rx_vld and 0xEB -> SYNC1; xor_acc = 0xEB.
  - SYNC1: on rx_vld and 0x90 -> HEAD, byte count 2. On rx_vld and 0xEB -> stay SYNC1 (acc reset to 0xEB). Other byte -> IDLE, no error, no pkt_done.
  - HEAD: capture bytes 2..4 into shadow registers. After byte 11 -> LOAD, payload counter 0.
  - LOAD: each accepted byte drives pay_data/pay_vld on the next cycle (1-cycle latency). After len_cur bytes -> CHK.
  - CHK: compare accepted byte with xor_acc. Next cycle: pkt_done = 1 with exactly one of pkt_ok / pkt_err_crc. On ok, copy shadow type/seq to pkt_type/pkt_seq and increment cnt_ok; otherwise increment cnt_err. -> IDLE.
- Timeout: active in HEAD/LOAD/CHK only. Gap counter resets on each accepted byte. When it reaches TOUT: pkt_done + pkt_err_tout, cnt_err + 1, -> IDLE, partial payload already forwarded stays forwarded. Not active in IDLE/SYNC1.
- pkt_ok/pkt_err_* are valid only in the pkt_done cycle and are 0 otherwise.
- Simultaneous events: a byte accepted in the same cycle the gap counter would hit TOUT counts as accepted; no timeout. The cycle after pkt_done, IDLE accepts a new 0xEB.
- rst asserted mid-packet: immediate return to IDLE; outputs and counters cleared; no pkt_done.
- Counter saturation: at 16'hFFFF further increments are dropped.

Test Plan:
- SIM_LEN=1, cfg_sample=1: send EB 90 05 12 34 + 7×00 + 9 payload bytes 01..09 + correct XOR -> 9 pay_vld pulses carrying 01..09; pkt_done with pkt_ok=1; pkt_type=05, pkt_seq=1234, cnt_ok=1.
- Same packet with check byte inverted -> pkt_err_crc=1, pkt_ok=0; cnt_err=1; pkt_type/pkt_seq keep previous values.
- Junk 00 EB EB 90 ... then valid packet -> double-EB resync; packet parses ok; no pkt_done for the junk.
- TOUT=20: stop after payload byte 4 for 20 cycles -> pkt_done with pkt_err_tout; 4 pay_vld pulses seen; next valid packet parses ok.
- cfg_sample=7 with SIM_LEN=1 -> 180-byte payload expected. Change cfg_sample to 1 after the header -> packet still needs 180 payload bytes.
- rst pulse during LOAD -> all outputs 0 and no pkt_done; a following packet parses ok with cnt_ok=1.
